// File: rtl/pulse_cmd_pkg.sv
// Shared definitions for the pulse-board command protocol: control codes,
// frame length and the host-side sender state encoding.
package pulse_cmd_pkg;

    localparam logic [7:0] CONT_SET_DELAY     = 8'd0;
    localparam logic [7:0] CONT_SET_PERIOD    = 8'd1;
    localparam logic [7:0] CONT_SET_PULSE1    = 8'd2;
    localparam logic [7:0] CONT_SET_PULSE2    = 8'd3;
    localparam logic [7:0] CONT_TOGGLE_PULSE1 = 8'd4;
    localparam logic [7:0] CONT_SET_CPMG      = 8'd5;
    localparam logic [7:0] CONT_SET_ATT       = 8'd6;
    localparam logic [7:0] CONT_SET_NUTW      = 8'd7;
    localparam logic [7:0] CONT_SET_NUTD      = 8'd8;

    localparam int FRAME_BYTES = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_WAIT_ECHO = 3'd4,
        ST_CHECK     = 3'd5,
        ST_REPORT    = 3'd6
    } sender_state_t;

    typedef enum logic [1:0] {
        RES_MATCH    = 2'd0,
        RES_MISMATCH = 2'd1,
        RES_TIMEOUT  = 2'd2
    } echo_result_t;

    // Checksum covers the four value bytes only; the control byte is excluded.
    function automatic logic [7:0] value_checksum(input logic [31:0] v);
        return v[7:0] + v[15:8] + v[23:16] + v[31:24];
    endfunction

endpackage

// File: rtl/pulse_cmd_sender.sv
// Host-side command initiator: serialises value (LSB first) plus control byte
// over a byte UART, then verifies the responder's checksum echo with retry.
module pulse_cmd_sender
    import pulse_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_control,
    input  logic [31:0]   cmd_value,
    output logic          transmit,
    output logic [7:0]    tx_byte,
    input  logic          is_transmitting,
    input  logic          received,
    input  logic [7:0]    rx_byte,
    input  logic          recv_error,
    output logic          busy,
    output logic          done,
    output logic          ok,
    output logic          err_checksum,
    output logic          err_timeout,
    output logic [1:0]    retries_used,
    output sender_state_t dbg_state
);

    localparam int         CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
    localparam logic [1:0] MAX_R    = 2'(MAX_RETRIES);

    sender_state_t    state_q, state_d;
    echo_result_t     res_q;
    logic [31:0]      value_q;
    logic [7:0]       control_q;
    logic [7:0]       expected_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retries_q;
    logic             ready_q;
    logic             rx_prev_q;
    logic             ok_q, err_cs_q, err_to_q;
    logic [7:0]       frame_byte;
    logic             rx_edge;
    logic             accept;
    logic             timeout_hit;

    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
    // cmd_ready is high only while idle, so requests during a command are dropped.
    assign accept      = cmd_valid && ready_q && (state_q == ST_IDLE);
    assign rx_edge     = received && !rx_prev_q;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        case (idx_q)
            3'd0:    frame_byte = value_q[7:0];
            3'd1:    frame_byte = value_q[15:8];
            3'd2:    frame_byte = value_q[23:16];
            3'd3:    frame_byte = value_q[31:24];
            default: frame_byte = control_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        transmit = 1'b0;
        tx_byte  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!is_transmitting) begin
                    transmit = 1'b1;
                    tx_byte  = frame_byte;
                    state_d  = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (is_transmitting) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (!is_transmitting) state_d = (idx_q == LAST_IDX) ? ST_WAIT_ECHO : ST_SEND;
            end
            ST_WAIT_ECHO: begin
                if (rx_edge || recv_error || timeout_hit) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (res_q == RES_MATCH || retries_q >= MAX_R) state_d = ST_REPORT;
                else                                          state_d = ST_SEND;
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            res_q      <= RES_MATCH;
            value_q    <= '0;
            control_q  <= '0;
            expected_q <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            retries_q  <= '0;
            ready_q    <= 1'b0;
            rx_prev_q  <= 1'b0;
            ok_q       <= 1'b0;
            err_cs_q   <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == ST_IDLE);
            rx_prev_q <= received;

            if (accept) begin
                value_q    <= cmd_value;
                control_q  <= cmd_control;
                expected_q <= value_checksum(cmd_value);
                idx_q      <= '0;
                retries_q  <= '0;
                ok_q       <= 1'b0;
                err_cs_q   <= 1'b0;
                err_to_q   <= 1'b0;
            end

            if (state_q == ST_WAIT_IDLE && !is_transmitting && idx_q != LAST_IDX)
                idx_q <= idx_q + 3'd1;

            if (state_q == ST_WAIT_IDLE)      cnt_q <= '0;
            else if (state_q == ST_WAIT_ECHO) cnt_q <= cnt_q + CNT_W'(1);

            // A received edge takes priority over an error or timeout in the same cycle.
            if (state_q == ST_WAIT_ECHO) begin
                if (rx_edge)          res_q <= (rx_byte == expected_q) ? RES_MATCH : RES_MISMATCH;
                else if (recv_error)  res_q <= RES_MISMATCH;
                else if (timeout_hit) res_q <= RES_TIMEOUT;
            end

            if (state_q == ST_CHECK) begin
                idx_q <= '0;
                if (res_q != RES_MATCH && retries_q < MAX_R) begin
                    retries_q <= retries_q + 2'd1;
                end else begin
                    ok_q     <= (res_q == RES_MATCH);
                    err_cs_q <= (res_q == RES_MISMATCH);
                    err_to_q <= (res_q == RES_TIMEOUT);
                end
            end
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_REPORT);
    assign done         = (state_q == ST_REPORT);
    assign ok           = ok_q;
    assign err_checksum = err_cs_q;
    assign err_timeout  = err_to_q;
    assign retries_used = retries_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// Bench for pulse_cmd_sender: UART byte model, echo responder, tx-byte
// scoreboard, vector table, reset corner case and randomized commands.
module tb_pulse_cmd_sender;
    import pulse_cmd_pkg::*;

    localparam int TIMEOUT = 1000;
    localparam int MAX_RET = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd_control = 8'h00;
    logic [31:0]   cmd_value = 32'h0;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic          is_transmitting = 1'b0;
    logic          received = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          recv_error = 1'b0;
    logic          busy, done, ok, err_checksum, err_timeout;
    logic [1:0]    retries_used;
    sender_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bytes_done = 0;
    int drop_cyc = 0;
    int tx_len;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] value;
        logic [7:0]  control;
        int          e0, e1, e2;   // echo per attempt: byte, -1 silent, -2 recv_error
        bit          level, stray, poke, chk_time;
        bit          x_ok, x_cs, x_to;
        int          x_r;
    } vec_t;

    vec_t vecs[9];

    pulse_cmd_sender #(.TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRIES(MAX_RET)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_control(cmd_control), .cmd_value(cmd_value), .transmit(transmit),
        .tx_byte(tx_byte), .is_transmitting(is_transmitting), .received(received),
        .rx_byte(rx_byte), .recv_error(recv_error), .busy(busy), .done(done), .ok(ok),
        .err_checksum(err_checksum), .err_timeout(err_timeout),
        .retries_used(retries_used), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- UART TX model ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n && transmit) begin
            @(posedge clk);
            #1 is_transmitting = 1'b1;
            tx_len = $urandom_range(2, 6);
            repeat (tx_len) @(posedge clk);
            #1 is_transmitting = 1'b0;
            bytes_done++;
            drop_cyc = cyc;
        end
    end

    // ---------------- scoreboard on transmitted bytes ----------------
    initial forever begin
        @(negedge clk);
        if (transmit) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %02h expected no strobe", tx_byte);
            end else begin
                logic [7:0] want;
                want = exp_q.pop_front();
                if (tx_byte !== want) begin
                    errors++;
                    $display("FAIL tx_byte got %02h expected %02h", tx_byte, want);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic int ref_sum(input logic [31:0] v);
        int s = 0;
        for (int i = 0; i < 4; i++) s += int'((v >> (8 * i)) & 32'hFF);
        return s % 256;
    endfunction

    // Outcome from the retry rules: first attempt whose echo equals the sum wins;
    // otherwise the last permitted attempt decides the error kind.
    task automatic ref_outcome(input logic [31:0] v, input int e0, input int e1, input int e2,
                               output bit o_ok, output bit o_cs, output bit o_to, output int o_r);
        int ech[3];
        int s;
        ech[0] = e0; ech[1] = e1; ech[2] = e2;
        s = ref_sum(v);
        o_ok = 0; o_cs = 0; o_to = 0; o_r = MAX_RET;
        for (int a = 0; a <= MAX_RET; a++) begin
            if (ech[a] == s) begin
                o_ok = 1; o_r = a;
                break;
            end
            if (a == MAX_RET) begin
                o_to = (ech[a] == -1);
                o_cs = !o_to;
            end
        end
    endtask

    task automatic push_frame(input logic [31:0] value, input logic [7:0] control);
        for (int i = 0; i < 4; i++) exp_q.push_back(value[8*i +: 8]);
        exp_q.push_back(control);
    endtask

    task automatic wait_bytes(input int target, input string name, output bit got);
        int n = 0;
        while (bytes_done < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        got = (bytes_done >= target);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s bytes got %0d expected %0d", name, bytes_done, target);
        end
    endtask

    task automatic accept_cmd(input string name, input logic [31:0] value, input logic [7:0] control);
        int n = 0;
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({name, " cmd_ready"}, cmd_ready, 1);
        cmd_value   = value;
        cmd_control = control;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({name, " busy_after_accept"}, busy, 1);
        check({name, " ready_after_accept"}, cmd_ready, 0);
    endtask

    task automatic apply_echo(input int e, input bit level);
        if (e >= 0) begin
            if (level && received) begin
                received = 1'b0;
                @(negedge clk);
            end
            rx_byte  = e[7:0];
            received = 1'b1;
            @(negedge clk);
            if (!level) received = 1'b0;
        end else if (e == -2) begin
            recv_error = 1'b1;
            @(negedge clk);
            recv_error = 1'b0;
        end
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        int ech[3];
        int base, n, done_cyc;
        bit got, seen;
        ech[0] = v.e0; ech[1] = v.e1; ech[2] = v.e2;
        base = bytes_done;
        for (int a = 0; a <= v.x_r; a++) push_frame(v.value, v.control);
        accept_cmd(name, v.value, v.control);
        if (v.stray) begin
            rx_byte  = 8'h55;
            received = 1'b1;
            @(negedge clk);
            received = 1'b0;
        end
        if (v.poke) begin
            repeat (3) @(negedge clk);
            cmd_value = ~v.value;
            cmd_valid = 1'b1;
            repeat (3) @(negedge clk);
            cmd_valid = 1'b0;
        end
        for (int a = 0; a <= v.x_r; a++) begin
            wait_bytes(base + FRAME_BYTES * (a + 1), name, got);
            if (!got) break;
            repeat (2) @(negedge clk);
            apply_echo(ech[a], v.level);
        end
        n = 0;
        seen = 0;
        while (n < 4000) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check({name, " done_seen"}, seen, 1);
        if (seen) begin
            check({name, " ok"}, ok, v.x_ok);
            check({name, " err_checksum"}, err_checksum, v.x_cs);
            check({name, " err_timeout"}, err_timeout, v.x_to);
            check({name, " retries_used"}, retries_used, v.x_r);
            check({name, " busy_at_done"}, busy, 0);
            // Echo window of TIMEOUT cycles, plus the cycle that registers the
            // idle UART and the CHECK cycle before done.
            if (v.chk_time) check({name, " timeout_latency"}, done_cyc - drop_cyc, TIMEOUT + 2);
            @(negedge clk);
            check({name, " done_one_cycle"}, done, 0);
            check({name, " ready_after_done"}, cmd_ready, 1);
            check({name, " ok_held"}, ok, v.x_ok);
            check({name, " retries_held"}, retries_used, v.x_r);
        end
        check({name, " frames_complete"}, exp_q.size(), 0);
        exp_q.delete();
        received = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t rv;
        int s, r, n;
        int ech[3];

        vecs[0] = '{32'h01020304, CONT_SET_DELAY,  'h0A, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0};
        vecs[1] = '{32'hFFFFFFFF, CONT_SET_CPMG,   'hFC, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0};
        vecs[2] = '{32'h00000010, CONT_SET_DELAY,  'h00, 'h00, 'h00, 0, 0, 0, 0, 0, 1, 0, 2};
        vecs[3] = '{32'h01020304, CONT_SET_DELAY,  'h33, 'h0A, 0,  0, 1, 0, 0, 1, 0, 0, 1};
        vecs[4] = '{32'h12345678, CONT_SET_NUTW,   -1, -1, -1,     0, 0, 0, 1, 0, 0, 1, 2};
        vecs[5] = '{32'hA5A5A5A5, CONT_SET_PULSE1, -2, 'h94, 0,    0, 0, 0, 0, 1, 0, 0, 1};
        vecs[6] = '{32'h00000001, CONT_SET_PULSE2, 'h33, -1, -1,   1, 0, 0, 1, 0, 0, 1, 2};
        vecs[7] = '{32'hDEADBEEF, CONT_SET_NUTD,   'h38, 0, 0,     0, 0, 1, 0, 1, 0, 0, 0};
        vecs[8] = '{32'h80808080, CONT_SET_PERIOD, 'h11, 'h22, 'h00, 0, 0, 0, 0, 1, 0, 0, 2};

        // reset state
        repeat (3) @(negedge clk);
        check("rst transmit", transmit, 0);
        check("rst tx_byte", tx_byte, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ok", ok, 0);
        check("rst err_checksum", err_checksum, 0);
        check("rst err_timeout", err_timeout, 0);
        check("rst retries_used", retries_used, 0);
        check("rst state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst cmd_ready_after_release", cmd_ready, 1);

        for (int i = 0; i < 9; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

        // reset while byte 2 is being sent
        begin
            int base;
            bit got;
            base = bytes_done;
            push_frame(32'h01020304, CONT_SET_ATT);
            accept_cmd("midrst", 32'h01020304, CONT_SET_ATT);
            wait_bytes(base + 2, "midrst", got);
            n = 0;
            while (!transmit && !is_transmitting && n < 200) begin
                @(negedge clk);
                n++;
            end
            #1 rst_n = 1'b0;
            #1;
            check("midrst transmit", transmit, 0);
            check("midrst busy", busy, 0);
            check("midrst done", done, 0);
            check("midrst cmd_ready_in_reset", cmd_ready, 0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("midrst cmd_ready_after_release", cmd_ready, 1);
            check("midrst busy_after_release", busy, 0);
            exp_q.delete();
            n = 0;
            while (is_transmitting && n < 100) begin
                @(negedge clk);
                n++;
            end
            repeat (3) @(negedge clk);
            check("midrst no_strobe_after_reset", exp_q.size(), 0);
        end

        run_cmd("post_reset", vecs[0]);

        // randomized commands against the reference outcome
        for (int k = 0; k < 16; k++) begin
            rv.value   = $urandom;
            rv.control = 8'($urandom_range(0, 8));
            s = ref_sum(rv.value);
            for (int a = 0; a < 3; a++) begin
                r = $urandom_range(0, 9);
                if (r <= 4)      ech[a] = s;
                else if (r == 7) ech[a] = -2;
                else if (r == 8) ech[a] = -1;
                else             ech[a] = (s ^ $urandom_range(1, 255)) & 255;
            end
            rv.e0 = ech[0]; rv.e1 = ech[1]; rv.e2 = ech[2];
            rv.level = 0;
            rv.stray = 1'($urandom_range(0, 1));
            rv.poke  = 1'($urandom_range(0, 1));
            rv.chk_time = 0;
            ref_outcome(rv.value, rv.e0, rv.e1, rv.e2, rv.x_ok, rv.x_cs, rv.x_to, rv.x_r);
            run_cmd($sformatf("rand%0d", k), rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
